// File: rtl/ped_request_ctrl_if.sv
// rtl/ped_request_ctrl_if.sv - button/light-FSM signal bundle for the pedestrian request controller
interface ped_request_ctrl_if;
   logic       btn_n;
   logic       red_active;
   logic       ped_req;
   logic       walk;
   logic       wait_led;
   logic [7:0] req_count;

   modport master (
      output btn_n,
      output red_active,
      input  ped_req,
      input  walk,
      input  wait_led,
      input  req_count
   );

   modport slave (
      input  btn_n,
      input  red_active,
      output ped_req,
      output walk,
      output wait_led,
      output req_count
   );
endinterface

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian button sync/debounce, request latch and WALK/cooldown sequencer
module ped_request_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 540000,
   parameter int unsigned WALK_CYCLES     = 135000000,
   parameter int unsigned COOLDOWN_CYCLES = 54000000,
   parameter int          CNT_W           = 32
) (
   input  logic              clk,
   input  logic              rst,
   ped_request_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_WALK,
      ST_COOLDOWN
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic             pressed;
   logic             btn_stable;
   logic             stable_q;
   logic             press;
   logic [CNT_W-1:0] db_cnt;
   logic             red_q;
   logic             red_rise;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] timer_q;
   logic [CNT_W-1:0] timer_d;
   logic             pend_q;
   logic             pend_d;
   logic [7:0]       cnt_q;
   logic [7:0]       cnt_d;
   logic             ped_req_q;
   logic             ped_req_d;
   logic             walk_q;
   logic             walk_d;

   assign pressed  = ~sync2;
   assign press    = btn_stable & ~stable_q;
   assign red_rise = bus.red_active & ~red_q;

   // Synchroniser idles at 1 so a reset never looks like a held button.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         btn_stable <= 1'b0;
         stable_q   <= 1'b0;
         db_cnt     <= '0;
         red_q      <= 1'b0;
      end else begin
         sync1    <= bus.btn_n;
         sync2    <= sync1;
         stable_q <= btn_stable;
         red_q    <= bus.red_active;
         if (pressed == btn_stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_stable <= pressed;
            db_cnt     <= '0;
         end else begin
            db_cnt <= db_cnt + ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         pend_q    <= 1'b0;
         cnt_q     <= 8'd0;
         ped_req_q <= 1'b0;
         walk_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         ped_req_q <= ped_req_d;
         walk_q    <= walk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (press) begin
               state_d = ST_PENDING;
            end
         end
         // Only a fresh rising edge of RED grants, so a RED already in progress is skipped.
         ST_PENDING: begin
            if (red_rise) begin
               state_d = ST_WALK;
               timer_d = '0;
               cnt_d   = cnt_q + 8'd1;
            end
         end
         ST_WALK: begin
            if (press) begin
               pend_d = 1'b1;
            end
            if ((timer_q == WALK_LAST) || !bus.red_active) begin
               state_d = ST_COOLDOWN;
               timer_d = '0;
            end else begin
               timer_d = timer_q + ONE;
            end
         end
         ST_COOLDOWN: begin
            if (timer_q == CD_LAST) begin
               state_d = (pend_q || press) ? ST_PENDING : ST_IDLE;
               pend_d  = 1'b0;
               timer_d = '0;
            end else begin
               timer_d = timer_q + ONE;
               if (press) begin
                  pend_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
            pend_d  = 1'b0;
         end
      endcase
      ped_req_d = (state_d == ST_PENDING) || ((state_d == ST_COOLDOWN) && pend_d);
      walk_d    = (state_d == ST_WALK);
   end

   assign bus.ped_req   = ped_req_q;
   assign bus.wait_led  = ped_req_q;
   assign bus.walk      = walk_q;
   assign bus.req_count = cnt_q;

endmodule
